// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Merges register-file writes from two requesters (A and B) onto a single
//   bank write port. Each requester has one holding entry (occupied, addr,
//   data). At most one occupied entry is granted per cycle. The grant drives
//   the one-hot write enable and the write data, and the entry is freed at
//   the next edge.
//
//   Grant order:
//     - one entry occupied          -> grant it
//     - both occupied, same-edge load -> tie-break pointer rp (0 = A, 1 = B);
//                                      rp toggles after every such grant
//     - both occupied, different ages -> a_older flag selects
//   Writes to register 0 are granted and freed, but never enabled.
//
//   Optional feature, macro REGSCHED_BYPASS_EN:
//     When both entries are empty and exactly one requester is valid, that
//     request drives regwe/wdata in the same cycle and is not buffered.
//
// Handshake:
//   x_valid/x_ready follow strict valid/ready semantics. A transfer happens
//   at a rising edge where both are 1. x_ready is derived from registered
//   state only: it is 1 exactly when requester x's holding entry is empty.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A write channel
//   b_valid/b_ready/b_addr/b_data   requester B write channel
//   regwe [31:0]             one-hot write enables to the register bank
//   wdata [DATA_W-1:0]       write data to the bank
//   busy                     at least one holding entry occupied
module regfile_write_scheduler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [31:0]       regwe,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
);

  logic              a_occ;
  logic              b_occ;
  logic [4:0]        a_addr_q;
  logic [4:0]        b_addr_q;
  logic [DATA_W-1:0] a_data_q;
  logic [DATA_W-1:0] b_data_q;
  logic              rp;
  logic              a_older;
  // Both entries were loaded at the same edge; their age is equal, so rp
  // arbitrates instead of a_older.
  logic              tied;

  logic              grant_a;
  logic              grant_b;
  logic              tie_grant;
  logic              byp_a;
  logic              byp_b;
  logic              a_load;
  logic              b_load;

  logic              sel_v;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign a_ready = ~a_occ;
  assign b_ready = ~b_occ;
  assign busy    = a_occ | b_occ;

  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    tie_grant = 1'b0;
    if (a_occ && b_occ) begin
      if (tied) begin
        tie_grant = 1'b1;
        grant_a   = ~rp;
        grant_b   = rp;
      end else begin
        grant_a   = a_older;
        grant_b   = ~a_older;
      end
    end else begin
      grant_a = a_occ;
      grant_b = b_occ;
    end
  end

`ifdef REGSCHED_BYPASS_EN
  // A lone request into an empty scheduler is written straight through.
  // Reset suppresses it so no write leaves the block during reset.
  assign byp_a = ~reset & ~a_occ & ~b_occ & a_valid & ~b_valid;
  assign byp_b = ~reset & ~a_occ & ~b_occ & b_valid & ~a_valid;
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // A bypassed request completes its handoff without occupying the entry.
  assign a_load = a_valid & a_ready & ~byp_a;
  assign b_load = b_valid & b_ready & ~byp_b;

  always_comb begin
    sel_v    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (grant_a) begin
      sel_v    = 1'b1;
      sel_addr = a_addr_q;
      sel_data = a_data_q;
    end else if (grant_b) begin
      sel_v    = 1'b1;
      sel_addr = b_addr_q;
      sel_data = b_data_q;
    end else if (byp_a) begin
      sel_v    = 1'b1;
      sel_addr = a_addr;
      sel_data = a_data;
    end else if (byp_b) begin
      sel_v    = 1'b1;
      sel_addr = b_addr;
      sel_data = b_data;
    end
  end

  // Register 0 is hardwired to zero: the write is consumed but not enabled.
  // Reset blanks the port so a pending grant cannot reach the bank.
  always_comb begin
    regwe = '0;
    wdata = '0;
    if (sel_v && !reset) begin
      wdata = sel_data;
      if (sel_addr != 5'd0) regwe = 32'd1 << sel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_occ    <= 1'b0;
      b_occ    <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      rp       <= 1'b0;
      a_older  <= 1'b0;
      tied     <= 1'b0;
    end else begin
      // Load and free are exclusive per entry: load needs empty, grant needs occupied.
      if (grant_a) a_occ <= 1'b0;
      if (grant_b) b_occ <= 1'b0;
      if (a_load) begin
        a_occ    <= 1'b1;
        a_addr_q <= a_addr;
        a_data_q <= a_data;
      end
      if (b_load) begin
        b_occ    <= 1'b1;
        b_addr_q <= b_addr;
        b_data_q <= b_data;
      end
      if (tie_grant) rp <= ~rp;
      if (a_load && b_load)      tied <= 1'b1;
      else if (a_load || b_load) tied <= 1'b0;
      if (a_load && b_occ)       a_older <= 1'b1;
      else if (b_load && a_occ)  a_older <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Testbench for regfile_write_scheduler: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a reference model that
// tracks each holding entry with a load timestamp and grants the oldest one.
// Bank writes seen on the port are matched against an expected write queue.
module tb_regfile_write_scheduler;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [4:0]        a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [31:0]       regwe;
  logic [DATA_W-1:0] wdata;
  logic              busy;

  regfile_write_scheduler #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .regwe(regwe), .wdata(wdata), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: index 0 = A, 1 = B
  logic              m_occ [2];
  logic [4:0]        m_addr[2];
  logic [DATA_W-1:0] m_data[2];
  int                m_t   [2];
  logic              m_rp;
  int                cyc;

  logic [DATA_W-1:0] tb_bank[32];
  logic [4+DATA_W:0] exp_q[$];

  logic [31:0]       last_we;
  logic [DATA_W-1:0] last_wd;
  logic              last_ar, last_br, last_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver: one clock cycle with the given inputs; checks, then advances the model
  task automatic step(input logic r,
                      input logic av, input logic [4:0] aa, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [DATA_W-1:0] bd);
    int g;
    logic byp_a, byp_b, tie, ld_a, ld_b;
    logic [31:0] e_we;
    logic [DATA_W-1:0] e_wd;
    logic [4:0] e_addr;
    logic [4+DATA_W:0] item;
    @(negedge clk);
    reset = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    g = -1; tie = 1'b0;
    if (!r) begin
      if (m_occ[0] && !m_occ[1]) g = 0;
      else if (m_occ[1] && !m_occ[0]) g = 1;
      else if (m_occ[0] && m_occ[1]) begin
        if (m_t[0] < m_t[1]) g = 0;
        else if (m_t[1] < m_t[0]) g = 1;
        else begin g = m_rp ? 1 : 0; tie = 1'b1; end
      end
    end
    byp_a = 1'b0; byp_b = 1'b0;
`ifdef REGSCHED_BYPASS_EN
    if (!r && !m_occ[0] && !m_occ[1]) begin
      byp_a = av && !bv;
      byp_b = bv && !av;
    end
`endif
    e_we = '0; e_wd = '0; e_addr = '0;
    if (g >= 0) begin
      e_addr = m_addr[g]; e_wd = m_data[g];
    end else if (byp_a) begin
      e_addr = aa; e_wd = ad;
    end else if (byp_b) begin
      e_addr = ba; e_wd = bd;
    end
    if ((g >= 0 || byp_a || byp_b) && e_addr != 0) e_we = 32'd1 << e_addr;
    chk("a_ready", a_ready, !m_occ[0]);
    chk("b_ready", b_ready, !m_occ[1]);
    chk("busy", busy, m_occ[0] || m_occ[1]);
    chk("regwe", regwe, e_we);
    chk("wdata", wdata, e_wd);
    chk("onehot", $onehot0(regwe), 1);
    last_we = regwe; last_wd = wdata;
    last_ar = a_ready; last_br = b_ready; last_busy = busy;
    // scoreboard: expected writes in, observed writes out
    if (e_we != 0) exp_q.push_back({e_addr, e_wd});
    if (regwe != 0) begin
      if (exp_q.size() == 0) chk("wr_unexp", regwe, 0);
      else begin
        item = exp_q.pop_front();
        chk("wr_order", {$clog2(regwe), wdata}, item);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 32; i++) if (last_we[i]) tb_bank[i] = last_wd;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_occ[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; m_t[i] = 0;
      end
      m_rp = 1'b0;
    end else begin
      ld_a = av && !m_occ[0] && !byp_a;
      ld_b = bv && !m_occ[1] && !byp_b;
      if (g >= 0) m_occ[g] = 1'b0;
      if (tie) m_rp = ~m_rp;
      if (ld_a) begin m_occ[0] = 1'b1; m_addr[0] = aa; m_data[0] = ad; m_t[0] = cyc; end
      if (ld_b) begin m_occ[1] = 1'b1; m_addr[1] = ba; m_data[1] = bd; m_t[1] = cyc; end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    exp_q.delete();
  endtask

  initial begin
    cyc = 0;
    m_rp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_occ[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; m_t[i] = 0;
    end
    for (int i = 0; i < 32; i++) tb_bank[i] = '0;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);

    // reset then idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("idle_we", last_we, 32'h0);
      chk("idle_rdy", {last_ar, last_br, last_busy}, 3'b110);
    end

    // single handoff from A to register 5
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    idle(1);
`ifndef REGSCHED_BYPASS_EN
    chk("s2_we", last_we, 32'h20);
    chk("s2_wd", last_wd, 32'hDEADBEEF);
    chk("s2_ardy0", last_ar, 1'b0);
    idle(1);
    chk("s2_ardy1", last_ar, 1'b1);
`endif
    idle(2);

    // same-edge handoff, tie-break by rp; repeated to see rp flip
    do_reset();
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    idle(1);
    chk("tie1_first", last_we, 32'h8);
    idle(1);
    chk("tie1_second", last_we, 32'h80);
    chk("tie1_rp", dut.rp, m_rp);
    chk("tie1_rp1", m_rp, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    idle(1);
    chk("tie2_first", last_we, 32'h80);
    idle(1);
    chk("tie2_second", last_we, 32'h8);
    idle(1);

    // same destination, A then B one cycle later: B's data persists
    step(1'b0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, '0);
    step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 32'hBB);
    idle(3);
    chk("same_addr", tb_bank[9], 32'hBB);

    // write to register 0 from B is dropped
    step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("z_we0", last_we, 32'h0);
    idle(1);
    chk("z_we1", last_we, 32'h0);
    idle(1);
    chk("z_brdy", last_br, 1'b1);
    chk("z_we2", last_we, 32'h0);

    // reset while both entries are occupied
    step(1'b0, 1'b1, 5'd12, 32'h1234, 1'b1, 5'd13, 32'h5678);
    for (int i = 0; i < 32; i++) tb_bank[i] = '0;
    do_reset();
    chk("rst_we", last_we, 32'h0);
    idle(1);
    chk("rst_state", {last_ar, last_br, last_busy}, 3'b110);
    chk("rst_we2", last_we, 32'h0);
    idle(2);
    chk("rst_nowrite12", tb_bank[12], 32'h0);
    chk("rst_nowrite13", tb_bank[13], 32'h0);

`ifdef REGSCHED_BYPASS_EN
    // lone request into empty scheduler goes straight through
    step(1'b0, 1'b1, 5'd2, 32'h5, 1'b0, 5'd0, '0);
    chk("byp_we", last_we, 32'h4);
    chk("byp_ardy", last_ar, 1'b1);
    idle(1);
    chk("byp_after", last_we, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, av, bv;
      logic [4:0] aa, ba;
      r  = ($urandom_range(0, 49) == 0);
      av = ($urandom_range(0, 2) != 0);
      bv = ($urandom_range(0, 2) != 0);
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step(r, av, aa, $urandom, bv, ba, $urandom);
      if (r) exp_q.delete();
    end
    idle(4);
    chk("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
